inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Fetch stage sitting directly upstream of the instruction memory. Owns the program
//  counter, drives the word-aligned byte address into the combinational instruction ROM,
//  and registers the returned word plus its PC into an IF/ID register with a valid flag.
//  Supports decode-side stall, branch/jump redirect with flush, and halt on an all-zero
//  word (unused ROM is zero-filled).
// PARAMETERS
//  ADDR_W    8       byte-address width; PC wraps modulo 2**ADDR_W
//  INST_W    32      instruction width
//  RESET_PC  0       PC value loaded on reset (low 2 bits forced to 0)
//  CNT_W     16      width of fetch_count
// PORTS
//  clk              in   1        clock, all state updates on rising edge
//  reset            in   1        synchronous, active-high reset
//  stall            in   1        decode not ready: hold PC and IF/ID register
//  redirect         in   1        branch/jump taken: load redirect_target, flush IF/ID
//  redirect_target  in   ADDR_W   new byte address (low 2 bits ignored)
//  imem_addr        out  ADDR_W   byte address to instruction memory (= pc, comb.)
//  imem_inst        in   INST_W   instruction word returned combinationally
//  if_valid         out  1        IF/ID holds a real instruction
//  if_inst          out  INST_W   registered instruction
//  if_pc            out  ADDR_W   PC of if_inst
//  if_pc_plus4      out  ADDR_W   if_pc + 4, wrapped
//  halted           out  1        fetch has stopped on an all-zero word
//  fetch_count      out  CNT_W    number of instructions issued (if_valid rising loads)
// BEHAVIOUR
//  - Reset (sync): pc=RESET_PC&~3, state=RUN, if_valid=0, if_inst=0, if_pc=0,
//    if_pc_plus4=0, halted=0, fetch_count=0. Reset overrides every other input.
//  - imem_addr = pc combinationally; pc[1:0] always 0.
//  - States RUN, HALT. Per-edge priority in RUN: redirect > stall > halt-detect > fetch.
//  - RUN, redirect=1: pc<=redirect_target&~3; if_valid<=0 (bubble); IF/ID data held;
//    applies even when stall=1.
//  - RUN, stall=1, no redirect: pc and all IF/ID outputs unchanged.
//  - RUN, imem_inst==0: -> HALT; if_valid<=0; pc held; halted<=1; counter unchanged.
//  - RUN, otherwise: if_inst<=imem_inst; if_pc<=pc; if_pc_plus4<=pc+4; if_valid<=1;
//    pc<=pc+4 (wrap 0xFC->0x00 for ADDR_W=8); fetch_count+=1, saturating at all-ones.
//  - Fetch latency: word at pc appears on if_inst one edge after pc is presented.
//  - HALT: pc, IF/ID held, if_valid=0; exits only on redirect (-> RUN, halted<=0,
//    pc<=target) or reset. stall ignored in HALT.
//  - Width: all PC arithmetic modulo 2**ADDR_W; no overflow flag.
// TESTING
//  1 Reset 2 cycles -> imem_addr=0x00, if_valid=0, halted=0, fetch_count=0.
//  2 Release reset with standard 20-word program -> edge1 if_inst=0x00007033 if_pc=0x00
//    if_pc_plus4=0x04; edge2 if_inst=0x00100093 if_pc=0x04.
//  3 stall=1 for 3 cycles at pc=0x08 -> imem_addr stays 0x08, if_inst=0x00100093 held,
//    fetch_count unchanged; release -> next if_inst=0x00200113.
//  4 redirect=1 target=0x31 with stall=1 -> if_valid=0 next edge, imem_addr=0x30;
//    following edge if_inst=0x0041a633, if_pc=0x30.
//  5 Free run from 0 -> after 20 valid issues pc=0x50 reads 0 -> halted=1, if_valid=0,
//    fetch_count=20, imem_addr stays 0x50; redirect to 0x00 -> halted=0, refetch 0x00007033.
//  6 redirect to 0xFC (nonzero word) -> if_pc=0xFC, if_pc_plus4=0x00, imem_addr wraps 0x00;
//    assert reset mid-stream -> next edge pc=0x00, if_valid=0, fetch_count=0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational instruction ROM and registers
// the returned word with its PC into the IF/ID register. It halts on an all-zero word.
module inst_fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int INST_W   = 32,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_inst,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC) & ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              if_valid_q, if_valid_d;
    logic [INST_W-1:0] if_inst_q, if_inst_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [ADDR_W-1:0] if_pc_plus4_q, if_pc_plus4_d;
    logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

    logic [ADDR_W-1:0] target_aligned;
    logic              inst_zero;
    logic              do_fetch;

    assign target_aligned = {redirect_target[ADDR_W-1:2], 2'b00};
    assign inst_zero      = (imem_inst == '0);
    assign do_fetch       = (state_q == ST_RUN) && !redirect && !stall && !inst_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= PC_RST;
            if_valid_q    <= 1'b0;
            if_inst_q     <= '0;
            if_pc_q       <= '0;
            if_pc_plus4_q <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_inst_q     <= if_inst_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Priority in RUN: redirect > stall > halt-detect > fetch; HALT leaves only on redirect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (!redirect && !stall && inst_zero) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (redirect) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_inst_d     = if_inst_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        fetch_count_d = fetch_count_q;
        if (redirect) begin
            pc_d       = target_aligned;
            if_valid_d = 1'b0;
        end else if (state_q == ST_HALT) begin
            if_valid_d = 1'b0;
        end else if (stall) begin
            if_valid_d = if_valid_q;
        end else if (inst_zero) begin
            if_valid_d = 1'b0;
        end
        if (do_fetch) begin
            if_inst_d     = imem_inst;
            if_pc_d       = pc_q;
            if_pc_plus4_d = pc_q + PC_INC;
            if_valid_d    = 1'b1;
            pc_d          = pc_q + PC_INC;
            if (fetch_count_q != '1) fetch_count_d = fetch_count_q + 1'b1;
        end
    end

    always_comb begin
        imem_addr   = pc_q;
        if_valid    = if_valid_q;
        if_inst     = if_inst_q;
        if_pc       = if_pc_q;
        if_pc_plus4 = if_pc_plus4_q;
        fetch_count = fetch_count_q;
        halted      = (state_q == ST_HALT);
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a 20-word program ROM followed by zero fill,
// plus a nonzero word at 0xFC for the wrap case.
module tb_inst_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_target;
    logic [7:0]  imem_addr;
    logic [31:0] imem_inst;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [7:0]  if_pc;
    logic [7:0]  if_pc_plus4;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] rom [64];
    int checks;
    int failures;
    int issued;

    inst_fetch_unit #(
        .ADDR_W(8), .INST_W(32), .RESET_PC(0), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_inst(imem_inst),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
        .halted(halted), .fetch_count(fetch_count)
    );

    assign imem_inst = rom[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        issued   = 0;
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        rom[0]  = 32'h00007033;
        rom[1]  = 32'h00100093;
        rom[2]  = 32'h00200113;
        for (int i = 3; i < 20; i++) rom[i] = 32'h00000093 | (32'(i) << 20);
        rom[12] = 32'h0041a633;
        rom[63] = 32'hdeadbeef;

        // Reset
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 8'h00;
        step(); step();
        check("rst_addr", 32'(imem_addr), 32'h00);
        check("rst_valid", 32'(if_valid), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_count", 32'(fetch_count), 32'h0);
        check("rst_inst", if_inst, 32'h0);
        check("rst_pc4", 32'(if_pc_plus4), 32'h0);

        // First two fetches
        reset = 1'b0;
        step();
        check("e1_inst", if_inst, 32'h00007033);
        check("e1_pc", 32'(if_pc), 32'h00);
        check("e1_pc4", 32'(if_pc_plus4), 32'h04);
        check("e1_valid", 32'(if_valid), 32'h1);
        check("e1_count", 32'(fetch_count), 32'd1);
        step();
        check("e2_inst", if_inst, 32'h00100093);
        check("e2_pc", 32'(if_pc), 32'h04);
        check("e2_addr", 32'(imem_addr), 32'h08);

        // Stall three cycles at 0x08
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr", 32'(imem_addr), 32'h08);
            check("stall_inst", if_inst, 32'h00100093);
            check("stall_count", 32'(fetch_count), 32'd2);
        end
        stall = 1'b0;
        step();
        check("unstall_inst", if_inst, 32'h00200113);
        check("unstall_pc", 32'(if_pc), 32'h08);
        check("unstall_count", 32'(fetch_count), 32'd3);

        // Redirect wins over stall; target low bits dropped
        redirect = 1'b1; redirect_target = 8'h31; stall = 1'b1;
        step();
        check("redir_valid", 32'(if_valid), 32'h0);
        check("redir_addr", 32'(imem_addr), 32'h30);
        check("redir_inst_held", if_inst, 32'h00200113);
        check("redir_count", 32'(fetch_count), 32'd3);
        redirect = 1'b0; stall = 1'b0;
        step();
        check("redir_fetch_inst", if_inst, 32'h0041a633);
        check("redir_fetch_pc", 32'(if_pc), 32'h30);
        check("redir_fetch_valid", 32'(if_valid), 32'h1);

        // Free run from reset until halt on the zero-filled region
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 40 && !halted; i++) begin
            step();
            if (if_valid) issued++;
        end
        check("run_halted", 32'(halted), 32'h1);
        check("run_issued", 32'(issued), 32'd20);
        check("run_count", 32'(fetch_count), 32'd20);
        check("run_valid", 32'(if_valid), 32'h0);
        check("run_addr", 32'(imem_addr), 32'h50);
        check("run_last_pc", 32'(if_pc), 32'h4c);
        stall = 1'b1;
        step();
        stall = 1'b0;
        step();
        check("halt_hold_addr", 32'(imem_addr), 32'h50);
        check("halt_hold", 32'(halted), 32'h1);
        check("halt_hold_count", 32'(fetch_count), 32'd20);

        redirect = 1'b1; redirect_target = 8'h00;
        step();
        redirect = 1'b0;
        check("unhalt", 32'(halted), 32'h0);
        check("unhalt_addr", 32'(imem_addr), 32'h00);
        check("unhalt_valid", 32'(if_valid), 32'h0);
        step();
        check("refetch_inst", if_inst, 32'h00007033);
        check("refetch_count", 32'(fetch_count), 32'd21);

        // Wrap at top of address space
        redirect = 1'b1; redirect_target = 8'hfc;
        step();
        redirect = 1'b0;
        check("wrap_addr0", 32'(imem_addr), 32'hfc);
        step();
        check("wrap_pc", 32'(if_pc), 32'hfc);
        check("wrap_pc4", 32'(if_pc_plus4), 32'h00);
        check("wrap_inst", if_inst, 32'hdeadbeef);
        check("wrap_addr", 32'(imem_addr), 32'h00);
        step();
        check("wrap_next_inst", if_inst, 32'h00007033);

        // Reset mid-stream
        reset = 1'b1;
        step();
        check("mid_rst_addr", 32'(imem_addr), 32'h00);
        check("mid_rst_valid", 32'(if_valid), 32'h0);
        check("mid_rst_count", 32'(fetch_count), 32'h0);
        check("mid_rst_pc", 32'(if_pc), 32'h0);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
